// File: rtl/ram_pkg.sv
// Shared constants for the asynchronous-SRAM request responder: default
// geometry, FSM state encoding and the per-state strobe decode.
package ram_pkg;

  localparam int RAM_ADDR_W      = 26;
  localparam int RAM_DATA_W      = 16;
  localparam int RAM_WAIT_CYCLES = 7;

  // FSM state encoding (kept as plain constants for legacy tools).
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WR_SETUP  = 3'd1;
  localparam logic [2:0] ST_WR_PULSE  = 3'd2;
  localparam logic [2:0] ST_WR_HOLD   = 3'd3;
  localparam logic [2:0] ST_RD_ACCESS = 3'd4;
  localparam logic [2:0] ST_RD_DONE   = 3'd5;

  // Memory-side strobes plus busy, all derived from the state being entered.
  typedef struct packed {
    logic ce_n;
    logic we_n;
    logic oe_n;
    logic dq_oe;
    logic busy;
  } strobe_t;

  // Strobe levels for a given state. WR_SETUP/WR_HOLD keep the data bus
  // driven around the we_n pulse; RD_DONE already releases ce_n/oe_n.
  function automatic strobe_t state_strobes(input logic [2:0] st);
    strobe_t s;
    case (st)
      ST_IDLE:      s = '{ce_n: 1'b1, we_n: 1'b1, oe_n: 1'b1, dq_oe: 1'b0, busy: 1'b0};
      ST_WR_SETUP:  s = '{ce_n: 1'b0, we_n: 1'b1, oe_n: 1'b1, dq_oe: 1'b1, busy: 1'b1};
      ST_WR_PULSE:  s = '{ce_n: 1'b0, we_n: 1'b0, oe_n: 1'b1, dq_oe: 1'b1, busy: 1'b1};
      ST_WR_HOLD:   s = '{ce_n: 1'b0, we_n: 1'b1, oe_n: 1'b1, dq_oe: 1'b1, busy: 1'b1};
      ST_RD_ACCESS: s = '{ce_n: 1'b0, we_n: 1'b1, oe_n: 1'b0, dq_oe: 1'b0, busy: 1'b1};
      ST_RD_DONE:   s = '{ce_n: 1'b1, we_n: 1'b1, oe_n: 1'b1, dq_oe: 1'b0, busy: 1'b1};
      default:      s = '{ce_n: 1'b1, we_n: 1'b1, oe_n: 1'b1, dq_oe: 1'b0, busy: 1'b0};
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ram_responder.sv
// Single-port asynchronous SRAM responder. Accepts one write or read request
// while idle, sequences the active-low memory strobes over WAIT_CYCLES clocks
// and returns read data with a one-cycle read_ack. Every output comes straight
// from a flop; strobe levels are decoded from the next state so they switch
// in the same edge as the state register.
module ram_responder
  import ram_pkg::*;
#(
  parameter int ADDR_W      = RAM_ADDR_W,
  parameter int DATA_W      = RAM_DATA_W,
  parameter int WAIT_CYCLES = RAM_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_enable,
  input  logic              read_request,
  output logic              read_ack,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce_n,
  output logic              mem_we_n,
  output logic              mem_oe_n,
  output logic [DATA_W-1:0] mem_dq_out,
  output logic              mem_dq_oe,
  input  logic [DATA_W-1:0] mem_dq_in
);

  // Counter reload: the state is left on the edge where the counter reads 0,
  // so loading WAIT_CYCLES-1 gives exactly WAIT_CYCLES cycles in the state.
  localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES - 1);

  logic [2:0]        state_q,    state_d;
  logic [7:0]        cnt_q,      cnt_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] dq_out_q,   dq_out_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              ack_q,      ack_d;
  strobe_t           strb_q,     strb_d;

  // Next-state, counter, latch and strobe decode for the access sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    dq_out_d   = dq_out_q;
    data_out_d = data_out_q;
    ack_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Write wins over a simultaneous read; the read is simply dropped.
        if (write_enable) begin
          state_d  = ST_WR_SETUP;
          addr_d   = address;
          dq_out_d = data_in;
        end else if (read_request) begin
          state_d = ST_RD_ACCESS;
          addr_d  = address;
          cnt_d   = WAIT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        cnt_d   = WAIT_LOAD;
      end
      ST_WR_PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_WR_HOLD: begin
        state_d = ST_IDLE;
      end
      ST_RD_ACCESS: begin
        if (cnt_q == 8'd0) begin
          state_d    = ST_RD_DONE;
          data_out_d = mem_dq_in;
          ack_d      = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RD_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    strb_d = state_strobes(state_d);
  end

  // State, datapath and strobe registers; reset parks the memory interface.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= '0;
      dq_out_q   <= '0;
      data_out_q <= '0;
      ack_q      <= 1'b0;
      strb_q     <= '{ce_n: 1'b1, we_n: 1'b1, oe_n: 1'b1, dq_oe: 1'b0, busy: 1'b0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      dq_out_q   <= dq_out_d;
      data_out_q <= data_out_d;
      ack_q      <= ack_d;
      strb_q     <= strb_d;
    end
  end

  assign read_ack   = ack_q;
  assign data_out   = data_out_q;
  assign busy       = strb_q.busy;
  assign mem_addr   = addr_q;
  assign mem_ce_n   = strb_q.ce_n;
  assign mem_we_n   = strb_q.we_n;
  assign mem_oe_n   = strb_q.oe_n;
  assign mem_dq_out = dq_out_q;
  assign mem_dq_oe  = strb_q.dq_oe;

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder with WAIT_CYCLES=3. Stimulus pushes the
// expected transaction when it issues a request; a monitor pops on each
// completed write pulse or read_ack and checks address, data and timing.
module tb_ram_responder;

  localparam int AW = 26;
  localparam int DW = 16;
  localparam int WC = 3;

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic          write_enable;
  logic          read_request;
  logic          read_ack;
  logic [DW-1:0] data_out;
  logic          busy;
  logic [AW-1:0] mem_addr;
  logic          mem_ce_n;
  logic          mem_we_n;
  logic          mem_oe_n;
  logic [DW-1:0] mem_dq_out;
  logic          mem_dq_oe;
  logic [DW-1:0] mem_dq_in;

  txn_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   ack_count = 0;

  ram_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .write_enable(write_enable), .read_request(read_request),
    .read_ack(read_ack), .data_out(data_out), .busy(busy),
    .mem_addr(mem_addr), .mem_ce_n(mem_ce_n), .mem_we_n(mem_we_n),
    .mem_oe_n(mem_oe_n), .mem_dq_out(mem_dq_out), .mem_dq_oe(mem_dq_oe),
    .mem_dq_in(mem_dq_in)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", {63'd0, busy}, 64'd0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    @(negedge clk);
    address = a; data_in = d; write_enable = 1'b1;
    t.is_wr = 1'b1; t.addr = a; t.data = d;
    exp_q.push_back(t);
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] mem_val);
    txn_t t;
    @(negedge clk);
    address = a; mem_dq_in = mem_val; read_request = 1'b1;
    t.is_wr = 1'b0; t.addr = a; t.data = mem_val;
    exp_q.push_back(t);
    @(negedge clk);
    read_request = 1'b0;
  endtask

  // Monitor: run-length tracking of strobes and scoreboard pops.
  initial begin
    int   busy_run = 0, we_run = 0, oe_run = 0, dq_run = 0, exp_busy = 0;
    logic prev_we = 1'b1, prev_busy = 1'b0, prev_dq = 1'b0;
    txn_t t;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        busy_run = 0; we_run = 0; oe_run = 0; dq_run = 0;
        prev_we = 1'b1; prev_busy = 1'b0; prev_dq = 1'b0;
      end else begin
        check("strobe_excl", {62'd0, (!mem_we_n && !mem_oe_n), (!mem_oe_n && mem_dq_oe)}, 64'd0);
        if (busy)      busy_run++;
        if (!mem_we_n) we_run++;
        if (!mem_oe_n) oe_run++;
        if (mem_dq_oe) dq_run++;
        if (read_ack) begin
          ack_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_ack", 64'd1, 64'd0);
          end else begin
            t = exp_q.pop_front();
            check("rd_kind", {63'd0, t.is_wr}, 64'd0);
            check("rd_addr", 64'(mem_addr), 64'(t.addr));
            check("rd_data", 64'(data_out), 64'(t.data));
            check("rd_ack_latency", 64'(busy_run), 64'(WC + 1));
            check("rd_oe_len", 64'(oe_run), 64'(WC));
            exp_busy = WC + 1;
          end
        end
        if (!prev_we && mem_we_n) begin
          if (exp_q.size() == 0) begin
            check("unexpected_write", 64'd1, 64'd0);
          end else begin
            t = exp_q.pop_front();
            check("wr_kind", {63'd0, t.is_wr}, 64'd1);
            check("wr_addr", 64'(mem_addr), 64'(t.addr));
            check("wr_data", 64'(mem_dq_out), 64'(t.data));
            check("wr_we_len", 64'(we_run), 64'(WC));
            exp_busy = WC + 2;
          end
        end
        if (prev_busy && !busy) begin
          check("busy_len", 64'(busy_run), 64'(exp_busy));
          busy_run = 0;
        end
        if (prev_dq && !mem_dq_oe) begin
          check("dq_oe_len", 64'(dq_run), 64'(WC + 2));
          dq_run = 0;
        end
        if (mem_we_n) we_run = 0;
        if (mem_oe_n) oe_run = 0;
        prev_we = mem_we_n; prev_busy = busy; prev_dq = mem_dq_oe;
      end
    end
  end

  // Directed stimulus.
  initial begin
    txn_t t;
    int   snap, n, gap;
    reset = 1'b0; address = '0; data_in = '0;
    write_enable = 1'b0; read_request = 1'b0; mem_dq_in = '0;
    repeat (2) @(negedge clk);
    check("rst_strobes", {58'd0, mem_ce_n, mem_we_n, mem_oe_n, mem_dq_oe, busy, read_ack}, 64'h38);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_dq_out", 64'(mem_dq_out), 64'd0);
    check("rst_data_out", 64'(data_out), 64'd0);

    // Write 0x123/0xBEEF presented before release: taken on the first edge.
    address = 26'h000123; data_in = 16'hBEEF; write_enable = 1'b1;
    t.is_wr = 1'b1; t.addr = 26'h000123; t.data = 16'hBEEF;
    exp_q.push_back(t);
    #2 reset = 1'b1;
    @(negedge clk);
    check("first_edge_accept", {63'd0, busy}, 64'd1);
    write_enable = 1'b0;
    wait_idle();

    // Plain read.
    do_read(26'h00000AA, 16'h1234);
    wait_idle();
    check("rd_data_out", 64'(data_out), 64'h1234);

    // Write and read together: only the write runs.
    snap = ack_count;
    @(negedge clk);
    address = 26'h10; data_in = 16'h5555; write_enable = 1'b1; read_request = 1'b1;
    t.is_wr = 1'b1; t.addr = 26'h10; t.data = 16'h5555;
    exp_q.push_back(t);
    @(negedge clk);
    write_enable = 1'b0; read_request = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("simul_no_ack", 64'(ack_count), 64'(snap));

    // Second read pulse while busy is ignored.
    snap = ack_count;
    do_read(26'h2222, 16'h0F0F);
    address = 26'h3333; read_request = 1'b1;
    @(negedge clk);
    read_request = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("busy_read_ignored", 64'(ack_count), 64'(snap + 1));

    // Back-to-back read then write at the top address.
    do_read(26'h3FFFFFF, 16'hA5C3);
    address = 26'h0000001; data_in = 16'h8001; write_enable = 1'b1;
    t.is_wr = 1'b1; t.addr = 26'h0000001; t.data = 16'h8001;
    exp_q.push_back(t);
    n = 0;
    while (busy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    gap = 0;
    while (busy === 1'b0 && gap < 50) begin @(negedge clk); gap++; end
    write_enable = 1'b0;
    check("b2b_gap", 64'(gap), 64'd1);
    wait_idle();

    // Reset during WR_PULSE: strobes park with no clock edge.
    do_write(26'h55, 16'hDEAD);
    n = 0;
    while (mem_we_n !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    check("reached_wr_pulse", {63'd0, mem_we_n}, 64'd0);
    #2 reset = 1'b0;
    #1;
    check("abort_strobes", {59'd0, mem_ce_n, mem_we_n, mem_oe_n, mem_dq_oe, busy}, 64'h1C);
    check("abort_ack", {63'd0, read_ack}, 64'd0);
    check("abort_addr", 64'(mem_addr), 64'd0);
    exp_q.delete();
    @(negedge clk);
    #2 reset = 1'b1;

    // Recovery read, then data_out must hold while mem_dq_in moves.
    do_read(26'h3A, 16'h7E57);
    wait_idle();
    mem_dq_in = 16'h0000;
    repeat (4) @(negedge clk);
    check("data_out_hold", 64'(data_out), 64'h7E57);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
